// File: rtl/move_input_ctrl.sv
// Player input stage: synchronises and debounces the left/right buttons and turns them
// into a single pending move code with hold-to-repeat, cleared when the game step consumes it.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 3,
    parameter int REPEAT_RATE     = 2,
    parameter int CNT_W           = 8
) (
    input  logic       in_clka,
    input  logic       in_restart_n,
    input  logic       in_btn_left,
    input  logic       in_btn_right,
    input  logic       in_tick,
    output logic [1:0] out_move,
    output logic [1:0] out_dir_db
);

    localparam logic [1:0] MV_NONE  = 2'd0;
    localparam logic [1:0] MV_LEFT  = 2'd1;
    localparam logic [1:0] MV_RIGHT = 2'd2;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            db_q;
    logic [1:0]            db_d;
    logic [1:0][CNT_W-1:0] dbcnt_q;
    logic [1:0][CNT_W-1:0] dbcnt_d;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            held_q;
    logic [1:0]            move_q;

    logic [1:0]            dir_s;
    logic [CNT_W-1:0]      limit_s;

    // Debounce next-state: the count restarts whenever the input agrees with the accepted value.
    always_comb begin
        db_d    = db_q;
        dbcnt_d = dbcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dbcnt_q[i] == DB_LAST) begin
                    db_d[i]    = ~db_q[i];
                    dbcnt_d[i] = '0;
                end else begin
                    db_d[i]    = db_q[i];
                    dbcnt_d[i] = dbcnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                db_d[i]    = db_q[i];
                dbcnt_d[i] = '0;
            end
        end
    end

    // Two-flop synchroniser plus the debounce state registers.
    always_ff @(posedge in_clka) begin
        if (!in_restart_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            db_q    <= 2'b00;
            dbcnt_q <= '0;
        end else begin
            sync1_q <= {in_btn_right, in_btn_left};
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dbcnt_q <= dbcnt_d;
        end
    end

    // Both or neither button held means no direction.
    always_comb begin
        case (db_q)
            2'b01:   dir_s = MV_LEFT;
            2'b10:   dir_s = MV_RIGHT;
            default: dir_s = MV_NONE;
        endcase
    end

    // Tick count at which the current hold phase emits its next move.
    always_comb begin
        if (state_q == ST_DELAY) begin
            limit_s = DELAY_LAST;
        end else begin
            limit_s = RATE_LAST;
        end
    end

    // Hold/repeat FSM; a move set on this edge overrides a same-edge consume.
    always_ff @(posedge in_clka) begin
        if (!in_restart_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            held_q  <= MV_NONE;
            move_q  <= MV_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dir_s != MV_NONE) begin
                        move_q  <= dir_s;
                        held_q  <= dir_s;
                        cnt_q   <= '0;
                        state_q <= ST_DELAY;
                    end else if (in_tick) begin
                        move_q <= MV_NONE;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (dir_s == MV_NONE) begin
                        state_q <= ST_IDLE;
                        if (in_tick) begin
                            move_q <= MV_NONE;
                        end
                    end else if (dir_s != held_q) begin
                        move_q  <= dir_s;
                        held_q  <= dir_s;
                        cnt_q   <= '0;
                        state_q <= ST_DELAY;
                    end else if (in_tick) begin
                        if (cnt_q == limit_s) begin
                            move_q  <= dir_s;
                            cnt_q   <= '0;
                            state_q <= ST_REPEAT;
                        end else begin
                            move_q <= MV_NONE;
                            cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    held_q  <= MV_NONE;
                    move_q  <= MV_NONE;
                end
            endcase
        end
    end

    assign out_move   = move_q;
    assign out_dir_db = db_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_move_input_ctrl;

    logic       clk;
    logic       rst_n;
    logic       left;
    logic       right;
    logic       tick;
    logic [1:0] out_move;
    logic [1:0] out_dir_db;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    bit done   = 1'b0;

    typedef struct {
        int         at;
        logic [1:0] mv;
        logic [1:0] db;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0] rep_exp [10] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2),
        .CNT_W          (8)
    ) dut (
        .in_clka      (clk),
        .in_restart_n (rst_n),
        .in_btn_left  (left),
        .in_btn_right (right),
        .in_tick      (tick),
        .out_move     (out_move),
        .out_dir_db   (out_dir_db)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Posedge counter: after edge N the value seen at the following negedge is N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic [1:0] mv, input logic [1:0] db, input string nm);
        exp_t e;
        e.at = at;
        e.mv = mv;
        e.db = db;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expectation due at the current edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (e.at != cyc) begin
                    n_bad++;
                    $display("FAIL %s: check for edge %0d missed (now edge %0d)", e.nm, e.at, cyc);
                end else if (out_move !== e.mv || out_dir_db !== e.db) begin
                    n_bad++;
                    $display("FAIL %s @edge %0d: got move=%0d db=%b, expected move=%0d db=%b",
                             e.nm, cyc, out_move, out_dir_db, e.mv, e.db);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int c;

        // 1. Reset for two edges while the buttons toggle.
        rst_n = 1'b0;
        left  = 1'b1;
        right = 1'b0;
        tick  = 1'b0;
        push(1, 2'd0, 2'b00, "rst_edge1");
        push(2, 2'd0, 2'b00, "rst_edge2");
        push(3, 2'd0, 2'b00, "post_rst_a");
        push(5, 2'd0, 2'b00, "post_rst_b");
        @(negedge clk);
        left  = 1'b0;
        right = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        right = 1'b0;
        repeat (4) @(negedge clk);

        // 2. Clean left press: move appears 7 edges later, one edge after the debounced flip.
        c    = cyc;
        left = 1'b1;
        push(c + 6, 2'd0, 2'b01, "left_db_first");
        push(c + 7, 2'd1, 2'b01, "left_latency7");
        push(c + 8, 2'd1, 2'b01, "left_hold");
        repeat (8) @(negedge clk);
        tick = 1'b1;
        push(c + 9, 2'd0, 2'b01, "left_consumed");
        @(negedge clk);
        tick = 1'b0;
        left = 1'b0;
        push(c + 16, 2'd0, 2'b00, "left_released");
        repeat (8) @(negedge clk);

        // 3. Three-cycle glitch never gets accepted.
        c    = cyc;
        left = 1'b1;
        repeat (3) @(negedge clk);
        left = 1'b0;
        push(c + 6, 2'd0, 2'b00, "glitch_a");
        push(c + 9, 2'd0, 2'b00, "glitch_b");
        repeat (10) @(negedge clk);

        // 4. Hold right across ten consuming ticks.
        c     = cyc;
        right = 1'b1;
        push(c + 7, 2'd2, 2'b10, "right_press");
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            tick = 1'b1;
            push(cyc + 1, rep_exp[k], 2'b10, $sformatf("right_tick%0d", k + 1));
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
        right = 1'b0;
        push(cyc + 7, 2'd0, 2'b00, "right_released");
        repeat (10) @(negedge clk);

        // 5. Both held -> no move; releasing right yields left one edge after db=01.
        c    = cyc;
        left = 1'b1;
        push(c + 7, 2'd1, 2'b01, "both_left_first");
        repeat (8) @(negedge clk);
        tick = 1'b1;
        push(c + 9, 2'd0, 2'b01, "both_left_consumed");
        @(negedge clk);
        tick  = 1'b0;
        right = 1'b1;
        push(c + 15, 2'd0, 2'b11, "both_db");
        push(c + 18, 2'd0, 2'b11, "both_no_move");
        repeat (9) @(negedge clk);
        right = 1'b0;
        push(c + 24, 2'd0, 2'b01, "right_off_db");
        push(c + 25, 2'd1, 2'b01, "right_off_move");
        repeat (7) @(negedge clk);

        // 6. Reach REPEAT, reset mid-hold, then a fresh press with left still held.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick = 1'b1;
            push(cyc + 1, (k == 2) ? 2'd1 : 2'd0, 2'b01, $sformatf("pre_rst_tick%0d", k + 1));
            @(negedge clk);
            tick = 1'b0;
        end
        push(c + 32, 2'd1, 2'b01, "repeat_hold");
        @(negedge clk);
        rst_n = 1'b0;
        push(c + 33, 2'd0, 2'b00, "mid_hold_reset");
        @(negedge clk);
        rst_n = 1'b1;
        push(c + 39, 2'd0, 2'b01, "fresh_db");
        push(c + 40, 2'd1, 2'b01, "fresh_move");
        repeat (7) @(negedge clk);
        left = 1'b0;
        push(c + 47, 2'd1, 2'b00, "pending_kept");
        repeat (7) @(negedge clk);
        tick = 1'b1;
        push(c + 48, 2'd0, 2'b00, "idle_consume");
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
